// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle unsigned ALU with iterative multiply/divide and valid/ready handshakes
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       func,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic             zero,
    output logic             dbz,
    output logic             illegal
);

    localparam logic [4:0] F_ADD = 5'd0;
    localparam logic [4:0] F_SUB = 5'd1;
    localparam logic [4:0] F_MUL = 5'd2;
    localparam logic [4:0] F_DIV = 5'd3;
    localparam logic [4:0] F_MOD = 5'd4;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic [4:0]       func_r;
    logic [WIDTH-1:0] d_r;
    logic [WIDTH-1:0] p_hi;
    logic [WIDTH-1:0] p_lo;
    logic [CNT_W-1:0] cnt;
    logic             dbz_r;
    logic             ill_r;

    logic             accept;
    logic             iter_op;
    logic             last_iter;
    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   sub_s;
    logic [WIDTH:0]   mul_s;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;

    assign accept    = in_valid && (state == IDLE);
    assign iter_op   = (func == F_MUL) || (((func == F_DIV) || (func == F_MOD)) && (b != '0));
    assign last_iter = (cnt == LAST_ITER);

    // Single-cycle results (bit WIDTH is carry for ADD, borrow for SUB)
    assign add_s = {1'b0, a} + {1'b0, b};
    assign sub_s = {1'b0, a} - {1'b0, b};

    // Shift-add step: p_hi accumulates, p_lo shifts the multiplier out and the product low half in
    assign mul_s = {1'b0, p_hi} + {1'b0, (p_lo[0] ? d_r : {WIDTH{1'b0}})};

    // Restoring step: p_hi is the partial remainder, p_lo shifts the dividend out and quotient in
    assign div_sh   = {p_hi, p_lo[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, d_r};
    assign div_ge   = ~div_diff[WIDTH];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = iter_op ? BUSY : DONE;
            BUSY: if (last_iter) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result/flag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            func_r <= '0;
            d_r    <= '0;
            p_hi   <= '0;
            p_lo   <= '0;
            cnt    <= '0;
            dbz_r  <= 1'b0;
            ill_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    func_r <= func;
                    cnt    <= '0;
                    dbz_r  <= 1'b0;
                    ill_r  <= 1'b0;
                    case (func)
                        F_ADD: begin
                            p_lo <= add_s[WIDTH-1:0];
                            p_hi <= {{(WIDTH-1){1'b0}}, add_s[WIDTH]};
                        end
                        F_SUB: begin
                            p_lo <= sub_s[WIDTH-1:0];
                            p_hi <= {{(WIDTH-1){1'b0}}, sub_s[WIDTH]};
                        end
                        F_MUL: begin
                            p_hi <= '0;
                            p_lo <= b;
                            d_r  <= a;
                        end
                        F_DIV, F_MOD: begin
                            p_hi <= '0;
                            if (b == '0) begin
                                p_lo  <= '0;
                                dbz_r <= 1'b1;
                            end else begin
                                p_lo <= a;
                                d_r  <= b;
                            end
                        end
                        default: begin
                            p_hi  <= '0;
                            p_lo  <= '0;
                            ill_r <= 1'b1;
                        end
                    endcase
                end
                BUSY: begin
                    cnt <= cnt + CNT_W'(1);
                    if (func_r == F_MUL) begin
                        p_hi <= mul_s[WIDTH:1];
                        p_lo <= {mul_s[0], p_lo[WIDTH-1:1]};
                    end else begin
                        p_hi <= div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
                        p_lo <= {p_lo[WIDTH-2:0], div_ge};
                    end
                end
                DONE: if (out_ready) begin
                    p_hi  <= '0;
                    p_lo  <= '0;
                    dbz_r <= 1'b0;
                    ill_r <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Outputs are forced to zero outside DONE; MOD swaps quotient and remainder
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        y         = '0;
        y_hi      = '0;
        dbz       = 1'b0;
        illegal   = 1'b0;
        if (state == DONE) begin
            y       = (func_r == F_MOD) ? p_hi : p_lo;
            y_hi    = (func_r == F_MOD) ? p_lo : p_hi;
            dbz     = dbz_r;
            illegal = ill_r;
        end
        zero = (state == DONE) && (y == '0);
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard testbench for alu_seq
module tb_alu_seq;

    typedef struct {
        logic [15:0] y;
        logic [15:0] hi;
        logic        z;
        logic        dbz;
        logic        ill;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [4:0]  func = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] y;
    logic [15:0] y_hi;
    logic        zero;
    logic        dbz;
    logic        illegal;

    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic [4:0]  func8 = '0;
    logic        out_valid8;
    logic [7:0]  y8;
    logic [7:0]  y_hi8;
    logic        zero8;
    logic        dbz8;
    logic        illegal8;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q16[$];
    exp_t q8[$];
    exp_t cur;
    exp_t cur8;
    logic have_cur = 1'b0;
    logic ov_prev = 1'b0;
    logic ov8_prev = 1'b0;

    alu_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .func(func), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .y_hi(y_hi), .zero(zero), .dbz(dbz), .illegal(illegal)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .func(func8), .out_valid(out_valid8), .out_ready(1'b1),
        .y(y8), .y_hi(y_hi8), .zero(zero8), .dbz(dbz8), .illegal(illegal8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor for the 16-bit instance
    always @(negedge clk) begin
        if (q16.size() > 0 && cyc >= q16[0].acc && !out_valid)
            chk({q16[0].name, "_busy_in_ready"}, 32'(in_ready), 32'd0);
        if (out_valid && !ov_prev) begin
            if (q16.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
                have_cur = 1'b0;
            end else begin
                cur = q16.pop_front();
                have_cur = 1'b1;
                chk({cur.name, "_y"}, 32'(y), 32'(cur.y));
                chk({cur.name, "_y_hi"}, 32'(y_hi), 32'(cur.hi));
                chk({cur.name, "_zero"}, 32'(zero), 32'(cur.z));
                chk({cur.name, "_dbz"}, 32'(dbz), 32'(cur.dbz));
                chk({cur.name, "_illegal"}, 32'(illegal), 32'(cur.ill));
                chk({cur.name, "_latency"}, 32'(cyc - cur.acc + 1), 32'(cur.lat));
            end
        end else if (out_valid && have_cur) begin
            chk({cur.name, "_hold_y"}, 32'(y), 32'(cur.y));
            chk({cur.name, "_hold_y_hi"}, 32'(y_hi), 32'(cur.hi));
        end
        if (out_valid) chk("done_in_ready", 32'(in_ready), 32'd0);
        ov_prev = out_valid;
    end

    // Monitor for the 8-bit instance
    always @(negedge clk) begin
        if (out_valid8 && !ov8_prev) begin
            if (q8.size() == 0) begin
                chk("unexpected_out_valid8", 32'd1, 32'd0);
            end else begin
                cur8 = q8.pop_front();
                chk({cur8.name, "_y"}, 32'(y8), 32'(cur8.y));
                chk({cur8.name, "_y_hi"}, 32'(y_hi8), 32'(cur8.hi));
                chk({cur8.name, "_zero"}, 32'(zero8), 32'(cur8.z));
                chk({cur8.name, "_latency"}, 32'(cyc - cur8.acc + 1), 32'(cur8.lat));
            end
        end
        ov8_prev = out_valid8;
    end

    task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic [4:0] f,
                         input logic [15:0] ey, input logic [15:0] ehi, input logic edbz,
                         input logic eill, input int lat, input string nm);
        exp_t e;
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        a = ia;
        b = ib;
        func = f;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            chk({nm, "_accept_timeout"}, 32'd1, 32'd0);
            in_valid = 1'b0;
            return;
        end
        e.y = ey; e.hi = ehi; e.z = (ey == 16'h0); e.dbz = edbz; e.ill = eill;
        e.lat = lat; e.acc = cyc + 1; e.name = nm;
        q16.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q16.size() > 0 || q8.size() > 0 || out_valid || out_valid8) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_idle_outputs(input string nm);
        chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({nm, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({nm, "_y"}, 32'(y), 32'd0);
        chk({nm, "_y_hi"}, 32'(y_hi), 32'd0);
        chk({nm, "_flags"}, 32'({zero, dbz, illegal}), 32'd0);
    endtask

    initial begin
        exp_t e;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        chk("reset_in_ready8", 32'(in_ready8), 32'd1);
        rst_n = 1'b1;

        issue(16'hFFFF, 16'h0001, 5'd0, 16'h0000, 16'h0001, 1'b0, 1'b0, 1,  "add_wrap");
        issue(16'h1234, 16'h0100, 5'd2, 16'h3400, 16'h0012, 1'b0, 1'b0, 17, "mul");
        issue(16'd1000, 16'd7,    5'd3, 16'd142,  16'd6,    1'b0, 1'b0, 17, "div");
        issue(16'd1000, 16'd7,    5'd4, 16'd6,    16'd142,  1'b0, 1'b0, 17, "mod");
        issue(16'd5,    16'd0,    5'd3, 16'h0000, 16'h0000, 1'b1, 1'b0, 1,  "div_by_zero");
        issue(16'd5,    16'd3,    5'd9, 16'h0000, 16'h0000, 1'b0, 1'b1, 1,  "illegal9");
        issue(16'd1,    16'd1,    5'd31,16'h0000, 16'h0000, 1'b0, 1'b1, 1,  "illegal31");
        issue(16'd7,    16'd0,    5'd4, 16'h0000, 16'h0000, 1'b1, 1'b0, 1,  "mod_by_zero");
        issue(16'hFFFF, 16'hFFFF, 5'd2, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 17, "mul_max");
        issue(16'hFFFF, 16'd1,    5'd3, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 17, "div_by_one");
        issue(16'd3,    16'd5,    5'd3, 16'h0000, 16'd3,    1'b0, 1'b0, 17, "div_small");
        issue(16'd5,    16'd3,    5'd1, 16'd2,    16'h0000, 1'b0, 1'b0, 1,  "sub");
        drain();

        // Backpressure: hold SUB result while the inputs wander
        out_ready = 1'b0;
        issue(16'd3, 16'd5, 5'd1, 16'hFFFE, 16'h0001, 1'b0, 1'b0, 1, "sub_bp");
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a = 16'(i * 3 + 100);
            b = 16'(i * 7 + 1);
            func = 5'(i);
            @(negedge clk);
        end
        a = 16'd9;
        b = 16'd4;
        func = 5'd0;
        out_ready = 1'b1;
        e.y = 16'd13; e.hi = 16'h0; e.z = 1'b0; e.dbz = 1'b0; e.ill = 1'b0;
        e.lat = 1; e.acc = cyc + 2; e.name = "add_after_drain";
        q16.push_back(e);
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        drain();

        // Reset in the middle of a multiply
        in_valid = 1'b1;
        a = 16'h1234;
        b = 16'h0100;
        func = 5'd2;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_idle_outputs("mid_reset");
        repeat (20) @(negedge clk);
        chk("mid_reset_no_result", 32'(out_valid), 32'd0);

        // 8-bit instance: DIV 200/3
        in_valid8 = 1'b1;
        a8 = 8'd200;
        b8 = 8'd3;
        func8 = 5'd3;
        e.y = 16'd66; e.hi = 16'd2; e.z = 1'b0; e.dbz = 1'b0; e.ill = 1'b0;
        e.lat = 9; e.acc = cyc + 1; e.name = "div8";
        q8.push_back(e);
        @(negedge clk);
        in_valid8 = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the 16-bit combinational integer ALU. Operand width is configurable.
- Multiply and divide/modulo run iteratively, one bit per cycle, instead of as single-cycle combinational arrays.
- Valid/ready handshakes on input and output. A second result word carries the high product or the other division result.
- Status flags. Sits between the register-read stage and writeback in the GPP datapath.

Parameters:
- WIDTH, 16, operand/result width in bits (>= 4).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands/func presented
- in_ready  output  1  block can accept an operation
- a  input  WIDTH  operand A (unsigned)
- b  input  WIDTH  operand B (unsigned)
- func  input  5  0=ADD 1=SUB 2=MUL 3=DIV 4=MOD, others illegal
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- y  output  WIDTH  primary result
- y_hi  output  WIDTH  secondary result
- zero  output  1  y == 0
- dbz  output  1  divide/mod by zero
- illegal  output  1  unsupported func

Behaviour:
- Reset and clocking: one clock, clk. Reset rst_n is synchronous and active-low.
  - While rst_n=0 at a rising edge: state goes to IDLE; counter cleared; in_ready=1 from the next cycle; out_valid, y, y_hi, zero, dbz, illegal all 0.
  - Reset mid-operation discards the operation silently.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid & in_ready, latch a, b, func.
    - ADD, SUB, illegal func, or DIV/MOD with b==0: go to DONE.
    - MUL, or DIV/MOD with b!=0: go to BUSY, counter=0.
  - BUSY: in_ready=0. One iteration per cycle. After WIDTH iterations (counter==WIDTH-1), go to DONE.
  - DONE: out_valid=1, results stable. On out_ready=1, go to IDLE.
    - in_ready=0 in DONE; no accept on the same edge as the result drains.
    - out_ready while not DONE is ignored.
- Latency, with accept at edge E:
  - Single-cycle ops: out_valid high from the cycle after E.
  - Iterative ops: out_valid high WIDTH+1 cycles after E.
  - Max throughput: one op per 2 cycles (single-cycle ops), one op per WIDTH+2 cycles (iterative ops).
- Operand capture: inputs a, b, func are ignored after accept until IDLE is re-entered.
- Arithmetic (all unsigned, modulo 2^WIDTH):
  - ADD: y=(a+b) truncated; y_hi=carry out in bit 0, other bits 0.
  - SUB: y=a-b wrapped; y_hi bit0=borrow (a<b), other bits 0.
  - MUL: shift-add. y=low WIDTH bits of a*b; y_hi=high WIDTH bits.
  - DIV: restoring division. y=a/b; y_hi=a%b.
  - MOD: y=a%b; y_hi=a/b.
- Divide/mod by zero (b==0 on DIV/MOD): y=0, y_hi=0, dbz=1. Single-cycle latency.
- Illegal func (5..31): y=0, y_hi=0, illegal=1. Single-cycle latency.
- Flags:
  - zero = (y==0), valid only while out_valid.
  - dbz, illegal: 0 except in DONE for the causing operation.
  - All flags are cleared on leaving DONE.
- Outputs outside DONE: y, y_hi and flags are 0.

Test Plan:
- Reset, then ADD a=16'hFFFF b=16'h0001 -> out_valid the cycle after accept; y=0000, y_hi=0001, zero=1.
- MUL a=16'h1234 b=16'h0100, WIDTH=16 -> out_valid exactly 17 cycles after accept; y=3400, y_hi=0012; in_ready=0 throughout.
- DIV a=1000 b=7, then MOD with same operands -> DIV gives y=142, y_hi=6; MOD gives y=6, y_hi=142; each 17 cycles.
- DIV a=5 b=0, then func=5'd9 -> y=0, dbz=1, latency 1; illegal op gives y=0, illegal=1, dbz=0.
- Backpressure and operand capture: hold out_ready=0 for 10 cycles after a SUB 3-5; change a/b/in_valid during BUSY and DONE -> y stays FFFE, y_hi=0001; no new accept until one cycle after the out_ready handshake.
- Reset mid-MUL (rst_n=0 at iteration 8), plus WIDTH=8 rerun of DIV 200/3 -> after reset all outputs 0, in_ready=1, no out_valid; WIDTH=8 DIV gives y=66, y_hi=2 after 9 cycles.
